// File: rtl/dp_arbiter_if.sv
// -----------------------------------------------------------------------------
// dp_arbiter_if
// Bundles the request, datapath and response channels around dp_arbiter.
//
// Parameters:
//   WIDTH  operand/result width
//   OP_W   op-code width
//
// Signals:
//   req0_valid/op/data/ready  requester 0 valid/ready channel
//   req1_valid/op/data/ready  requester 1 valid/ready channel
//   dp_issue/dp_op/dp_data    one-cycle issue strobe and operands to the datapath
//   dp_result                 datapath result, valid DP_LAT cycles after dp_issue
//   rsp_valid/id/data/ready   response channel tagged with the requester id
//
// Modports:
//   master  the arbiter side (drives readys, datapath issue and responses)
//   slave   the surrounding blocks (requesters, datapath, response consumer)
// -----------------------------------------------------------------------------
interface dp_arbiter_if #(
  parameter int WIDTH = 8,
  parameter int OP_W  = 2
);
  logic             req0_valid;
  logic [OP_W-1:0]  req0_op;
  logic [WIDTH-1:0] req0_data;
  logic             req0_ready;

  logic             req1_valid;
  logic [OP_W-1:0]  req1_op;
  logic [WIDTH-1:0] req1_data;
  logic             req1_ready;

  logic             dp_issue;
  logic [OP_W-1:0]  dp_op;
  logic [WIDTH-1:0] dp_data;
  logic [WIDTH-1:0] dp_result;

  logic             rsp_valid;
  logic             rsp_id;
  logic [WIDTH-1:0] rsp_data;
  logic             rsp_ready;

  modport master (
    input  req0_valid, req0_op, req0_data,
    output req0_ready,
    input  req1_valid, req1_op, req1_data,
    output req1_ready,
    output dp_issue, dp_op, dp_data,
    input  dp_result,
    output rsp_valid, rsp_id, rsp_data,
    input  rsp_ready
  );

  modport slave (
    output req0_valid, req0_op, req0_data,
    input  req0_ready,
    output req1_valid, req1_op, req1_data,
    input  req1_ready,
    input  dp_issue, dp_op, dp_data,
    output dp_result,
    input  rsp_valid, rsp_id, rsp_data,
    output rsp_ready
  );
endinterface

// File: rtl/dp_arbiter.sv
// -----------------------------------------------------------------------------
// dp_arbiter
// Round-robin sequencer sharing one fixed-latency 8-bit op datapath between two
// requesters. One operation is in flight at a time: accept, issue, wait the
// datapath latency, capture the result, hold it on the response channel until
// consumed.
//
// Parameters:
//   WIDTH   operand/result width
//   OP_W    op-code width
//   DP_LAT  cycles from dp_issue to a valid dp_result (>= 1)
//
// Ports:
//   clk   system clock, rising edge
//   rst   synchronous active-high reset
//   bus   dp_arbiter_if.master: request, datapath and response channels
//   busy  high whenever the sequencer is not idle (registered)
//
// All outputs are registered except req0_ready/req1_ready, which are decoded
// from state, the round-robin pointer and the request valids.
// -----------------------------------------------------------------------------
module dp_arbiter #(
  parameter int WIDTH  = 8,
  parameter int OP_W   = 2,
  parameter int DP_LAT = 1
) (
  input  logic         clk,
  input  logic         rst,
  dp_arbiter_if.master bus,
  output logic         busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam int               CNT_W    = (DP_LAT > 1) ? $clog2(DP_LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DP_LAT - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [OP_W-1:0]  op_q, op_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             id_q, id_d;
  logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic             last_q, last_d;     // requester granted by the last completed response
  logic             dp_issue_q, rsp_valid_q, busy_q;
  logic             ready0, ready1;

  // Grant and next-state decode.
  // NOTE: every variable assigned here gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    op_d       = op_q;
    data_d     = data_q;
    id_d       = id_q;
    rsp_data_d = rsp_data_q;
    last_d     = last_q;
    ready0     = 1'b0;
    ready1     = 1'b0;

    case (state_q)
      IDLE: begin
        // A lone requester always wins; under contention the one not served
        // last wins (last_q==1 hands the tie to requester 0).
        ready0 = bus.req0_valid && (!bus.req1_valid ||  last_q);
        ready1 = bus.req1_valid && (!bus.req0_valid || !last_q);
        if (ready0) begin
          op_d    = bus.req0_op;
          data_d  = bus.req0_data;
          id_d    = 1'b0;
          state_d = ISSUE;
        end else if (ready1) begin
          op_d    = bus.req1_op;
          data_d  = bus.req1_data;
          id_d    = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d   = CNT_LOAD;
        state_d = WAIT;
      end
      WAIT: begin
        if (cnt_q == '0) begin
          rsp_data_d = bus.dp_result;
          state_d    = RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RESP: begin
        // No new accept here even if rsp_ready is high; the next IDLE cycle
        // takes the next request.
        if (bus.rsp_ready) begin
          last_d  = id_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Registered outputs are computed from the next state so they line up with
  // the state they describe.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      op_q        <= '0;
      data_q      <= '0;
      id_q        <= 1'b0;
      rsp_data_q  <= '0;
      last_q      <= 1'b1;
      dp_issue_q  <= 1'b0;
      rsp_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      op_q        <= op_d;
      data_q      <= data_d;
      id_q        <= id_d;
      rsp_data_q  <= rsp_data_d;
      last_q      <= last_d;
      dp_issue_q  <= (state_d == ISSUE);
      rsp_valid_q <= (state_d == RESP);
      busy_q      <= (state_d != IDLE);
    end
  end

  assign bus.req0_ready = ready0;
  assign bus.req1_ready = ready1;
  assign bus.dp_issue   = dp_issue_q;
  assign bus.dp_op      = op_q;
  assign bus.dp_data    = data_q;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_id     = id_q;
  assign bus.rsp_data   = rsp_data_q;
  assign busy           = busy_q;

endmodule
